// File: rtl/queen_checker.sv
// rtl/queen_checker.sv - 12-queens answer checker: captures presets, checks 12 answer beats, issues one verdict.
// Optional idle timeout in RECV is enabled by defining QUEEN_CHK_TIMEOUT_EN.
module queen_checker #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] col,
  input  logic [3:0] row,
  input  logic       in_valid_num,
  input  logic [2:0] in_num,
  input  logic       ans_valid,
  input  logic [3:0] ans,
  output logic       out_valid,
  output logic       pass,
  output logic [2:0] err_code,
  output logic [3:0] err_col
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT   = 3'd2,
    RECV   = 3'd3,
    REPORT = 3'd4
  } state_t;

  localparam logic [3:0] NO_PRESET = 4'd12;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  preset_row [12];
  logic [11:0] row_used;
  logic [22:0] diag_sum;
  logic [22:0] diag_dif;
  logic [3:0]  ans_cnt;
  logic [2:0]  err_code_q;
  logic [3:0]  err_col_q;
  logic [3:0]  err_flags;
  logic [2:0]  num_q;

  logic        load_fire;
  logic        beat_fire;
  logic        timeout_fire;

  logic        range_err;
  logic        preset_err;
  logic        row_err;
  logic        diag_err;
  logic [3:0]  r_safe;
  logic [4:0]  sum_idx;
  logic [4:0]  dif_idx;
  logic [3:0]  c_preset;
  logic [3:0]  err_class;
  logic [2:0]  beat_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // in_valid wins over ans_valid while presets are still arriving
  always_comb begin
    state_nxt = state;
    load_fire = 1'b0;
    beat_fire = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load_fire = 1'b1;
          state_nxt = LOAD;
        end else if (ans_valid) begin
          beat_fire = 1'b1;
          state_nxt = RECV;
        end
      end
      LOAD: begin
        if (in_valid) begin
          load_fire = 1'b1;
        end else if (ans_valid) begin
          beat_fire = 1'b1;
          state_nxt = RECV;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (ans_valid) begin
          beat_fire = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (ans_valid) begin
          beat_fire = 1'b1;
          if (ans_cnt == 4'd11) begin
            state_nxt = REPORT;
          end
        end else if (timeout_fire) begin
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Out-of-range rows are steered to index 0 so no table is addressed past its end
  always_comb begin
    range_err  = (ans > 4'd11);
    r_safe     = range_err ? 4'd0 : ans;
    sum_idx    = {1'b0, r_safe} + {1'b0, ans_cnt};
    dif_idx    = {1'b0, r_safe} + 5'd11 - {1'b0, ans_cnt};
    c_preset   = (ans_cnt <= 4'd11) ? preset_row[ans_cnt] : NO_PRESET;
    preset_err = !range_err && (c_preset != NO_PRESET) && (c_preset != ans);
    row_err    = !range_err && !preset_err && row_used[r_safe];
    diag_err   = !range_err && !preset_err && !row_err &&
                 (diag_sum[sum_idx] || diag_dif[dif_idx]);
    err_class  = {diag_err, row_err, preset_err, range_err};
    beat_code  = 3'd0;
    if (range_err) begin
      beat_code = 3'd1;
    end else if (preset_err) begin
      beat_code = 3'd2;
    end else if (row_err) begin
      beat_code = 3'd3;
    end else if (diag_err) begin
      beat_code = 3'd4;
    end
  end

`ifdef QUEEN_CHK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != RECV || ans_valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle in RECV
  assign timeout_fire = (state == RECV) && !ans_valid &&
                        (idle_cnt == IW'(TIMEOUT_CYC - 1));
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 12; i++) begin
        preset_row[i] <= NO_PRESET;
      end
      row_used   <= '0;
      diag_sum   <= '0;
      diag_dif   <= '0;
      ans_cnt    <= '0;
      err_code_q <= '0;
      err_col_q  <= '0;
      err_flags  <= '0;
      num_q      <= '0;
      out_valid  <= 1'b0;
      pass       <= 1'b0;
      err_code   <= '0;
      err_col    <= '0;
    end else begin
      out_valid <= 1'b0;
      pass      <= 1'b0;
      err_code  <= '0;
      err_col   <= '0;

      if (load_fire) begin
        if (col <= 4'd11) begin
          preset_row[col] <= row;
        end
        if (in_valid_num && num_q == 3'd0) begin
          num_q <= in_num;
        end
      end

      if (beat_fire) begin
        if (!range_err) begin
          row_used[r_safe]  <= 1'b1;
          diag_sum[sum_idx] <= 1'b1;
          diag_dif[dif_idx] <= 1'b1;
        end
        // The first error is frozen; later classes only set their sticky flag
        if (beat_code != 3'd0 && err_flags == 4'd0) begin
          err_code_q <= beat_code;
          err_col_q  <= ans_cnt;
        end
        err_flags <= err_flags | err_class;
        ans_cnt   <= ans_cnt + 4'd1;
      end

      if (timeout_fire) begin
        err_code_q <= 3'd6;
        err_col_q  <= ans_cnt;
      end

      if (state == REPORT) begin
        out_valid <= 1'b1;
        pass      <= (err_code_q == 3'd0);
        err_code  <= err_code_q;
        err_col   <= err_col_q;
        for (int i = 0; i < 12; i++) begin
          preset_row[i] <= NO_PRESET;
        end
        row_used   <= '0;
        diag_sum   <= '0;
        diag_dif   <= '0;
        ans_cnt    <= '0;
        err_code_q <= '0;
        err_col_q  <= '0;
        err_flags  <= '0;
        num_q      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_queen_checker.sv
// tb/tb_queen_checker.sv - self-checking bench for queen_checker: vector table, hand sequences, random vs. model.
module tb_queen_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] col = '0;
  logic [3:0] row = '0;
  logic       in_valid_num = 1'b0;
  logic [2:0] in_num = '0;
  logic       ans_valid = 1'b0;
  logic [3:0] ans = '0;
  logic       out_valid;
  logic       pass;
  logic [2:0] err_code;
  logic [3:0] err_col;

  always #5 clk = ~clk;

  queen_checker #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .col(col), .row(row),
    .in_valid_num(in_valid_num), .in_num(in_num),
    .ans_valid(ans_valid), .ans(ans),
    .out_valid(out_valid), .pass(pass), .err_code(err_code), .err_col(err_col)
  );

  int tests = 0;
  int fails = 0;
  int pc[$];
  int pr[$];
  int a[12];
  int legal[12] = '{1, 3, 5, 7, 9, 11, 0, 2, 4, 6, 8, 10};

  typedef struct {
    string name;
    int    n_pre;
    int    pc0, pr0, pc1, pr1;
    int    kind;
    int    mut_col, mut_row;
    int    gap;
    int    exp_code, exp_col;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain N-queens rules over the whole answer, earlier legal columns only
  task automatic model(output int code, output int ecol);
    int prow[12];
    int cc;
    int r;
    bit rowhit;
    bit diaghit;
    for (int i = 0; i < 12; i++) prow[i] = 12;
    for (int i = 0; i < pc.size(); i++) if (pc[i] <= 11) prow[pc[i]] = pr[i];
    code = 0;
    ecol = 0;
    for (int c = 0; c < 12; c++) begin
      r = a[c];
      cc = 0;
      if (r > 11) cc = 1;
      else if (prow[c] != 12 && prow[c] != r) cc = 2;
      else begin
        rowhit = 0;
        diaghit = 0;
        for (int j = 0; j < c; j++) begin
          if (a[j] <= 11) begin
            if (a[j] == r) rowhit = 1;
            if ((a[j] - r == c - j) || (r - a[j] == c - j)) diaghit = 1;
          end
        end
        if (rowhit) cc = 3;
        else if (diaghit) cc = 4;
      end
      if (cc != 0 && code == 0) begin
        code = cc;
        ecol = c;
      end
    end
  endtask

  task automatic run_txn(input int gap, input int exp_code, input int exp_col,
                         input string name, input bit rst_on_pulse);
    int early = 0;
    int cyc;
    for (int i = 0; i < pc.size(); i++) begin
      in_valid = 1'b1;
      col = 4'(pc[i]);
      row = 4'(pr[i]);
      in_valid_num = (i == 0);
      in_num = 3'(pc.size());
      @(posedge clk); #1;
      if (out_valid) early++;
    end
    in_valid = 1'b0;
    in_valid_num = 1'b0;
    if (pc.size() > 0) begin
      repeat (gap) begin @(posedge clk); #1; if (out_valid) early++; end
    end
    for (int b = 0; b < 12; b++) begin
      ans_valid = 1'b1;
      ans = 4'(a[b]);
      @(posedge clk); #1;
      ans_valid = 1'b0;
      if (out_valid) early++;
      if (b != 11) begin
        repeat (gap) begin @(posedge clk); #1; if (out_valid) early++; end
      end
    end
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk({name, ".early"}, early, 0);
    chk({name, ".latency"}, cyc, 1);
    chk({name, ".pass"}, pass, (exp_code == 0));
    chk({name, ".err_code"}, err_code, exp_code);
    chk({name, ".err_col"}, err_col, exp_col);
    if (rst_on_pulse) begin
      rst_n = 1'b0;
      #1;
      chk({name, ".rst_out_valid"}, out_valid, 0);
      chk({name, ".rst_pass"}, pass, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      @(posedge clk); #1;
      chk({name, ".pulse_end"}, out_valid, 0);
      chk({name, ".zero_code"}, {pass, err_code, err_col}, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ecode, ecol, perm_mirror, np, cyc;
    bit seen;

    vecs[0] = '{"legal",      2, 0, 1, 6, 0, 0, -1, 0,  0, 0, 0};
    vecs[1] = '{"preset_mis", 2, 0, 1, 6, 0, 0,  0, 3,  0, 2, 0};
    vecs[2] = '{"row_conf",   0, 0, 0, 0, 0, 1, -1, 0,  0, 3, 1};
    vecs[3] = '{"diag_conf",  0, 0, 0, 0, 0, 2, -1, 0,  0, 4, 1};
    vecs[4] = '{"range_c4",   2, 0, 1, 6, 0, 0,  4, 12, 0, 1, 4};
    vecs[5] = '{"gaps",       2, 0, 1, 6, 0, 0, -1, 0,  3, 0, 0};
    vecs[6] = '{"dup_preset", 2, 0, 5, 0, 1, 0, -1, 0,  0, 0, 0};
    vecs[7] = '{"range_c11",  0, 0, 0, 0, 0, 0, 11, 15, 0, 1, 11};
    vecs[8] = '{"preset_c11", 1, 11, 3, 0, 0, 0, -1, 0, 0, 2, 11};
    vecs[9] = '{"gap_nopre",  0, 0, 0, 0, 0, 0, -1, 0,  2, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", out_valid, 0);
    chk("reset.pass", pass, 0);
    chk("reset.err_code", err_code, 0);
    chk("reset.err_col", err_col, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      pc.delete();
      pr.delete();
      if (vecs[v].n_pre >= 1) begin pc.push_back(vecs[v].pc0); pr.push_back(vecs[v].pr0); end
      if (vecs[v].n_pre >= 2) begin pc.push_back(vecs[v].pc1); pr.push_back(vecs[v].pr1); end
      for (int c = 0; c < 12; c++) begin
        case (vecs[v].kind)
          1:       a[c] = 5;
          2:       a[c] = c;
          default: a[c] = legal[c];
        endcase
      end
      if (vecs[v].mut_col >= 0) a[vecs[v].mut_col] = vecs[v].mut_row;
      run_txn(vecs[v].gap, vecs[v].exp_code, vecs[v].exp_col, vecs[v].name, 0);
    end

    // Abort after 5 beats: no verdict, then a fresh legal stream passes
    pc.delete();
    pr.delete();
    for (int b = 0; b < 5; b++) begin
      ans_valid = 1'b1;
      ans = 4'(legal[b]);
      @(posedge clk); #1;
    end
    ans_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("abort.no_verdict", seen, 0);
    for (int c = 0; c < 12; c++) a[c] = legal[c];
    run_txn(0, 0, 0, "post_abort", 0);

    // Reset while the verdict pulse is high clears outputs at once
    a[3] = 12;
    run_txn(1, 1, 3, "rst_pulse", 1);

    for (int t = 0; t < 30; t++) begin
      int base[12];
      perm_mirror = $urandom_range(1, 0);
      for (int c = 0; c < 12; c++) base[c] = perm_mirror ? 11 - legal[c] : legal[c];
      if ($urandom_range(3, 0) == 0) begin
        for (int i = 11; i > 0; i--) begin
          int j;
          int tmp;
          j = $urandom_range(i, 0);
          tmp = base[i];
          base[i] = base[j];
          base[j] = tmp;
        end
      end
      for (int c = 0; c < 12; c++) a[c] = base[c];
      if ($urandom_range(1, 0) == 1) a[$urandom_range(11, 0)] = $urandom_range(15, 0);
      pc.delete();
      pr.delete();
      np = $urandom_range(3, 0);
      for (int i = 0; i < np; i++) begin
        int cc;
        cc = $urandom_range(11, 0);
        pc.push_back(cc);
        pr.push_back(($urandom_range(3, 0) != 0) ? base[cc] : $urandom_range(11, 0));
      end
      model(ecode, ecol);
      run_txn($urandom_range(2, 0), ecode, ecol, $sformatf("rand%0d", t), 0);
    end

`ifdef QUEEN_CHK_TIMEOUT_EN
    pc.delete();
    pr.delete();
    for (int b = 0; b < 7; b++) begin
      ans_valid = 1'b1;
      ans = 4'(legal[b]);
      @(posedge clk); #1;
    end
    ans_valid = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk("timeout.latency_ok", (cyc >= 16 && cyc <= 17), 1);
    chk("timeout.pass", pass, 0);
    chk("timeout.err_code", err_code, 6);
    chk("timeout.err_col", err_col, 7);
    @(posedge clk); #1;
    for (int c = 0; c < 12; c++) a[c] = legal[c];
    run_txn(0, 0, 0, "post_timeout", 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
